// File: rtl/m68k_region_decoder_pkg.sv
// rtl/m68k_region_decoder_pkg.sv - shared encodings and reset table for the 68k region decoder
package m68k_decode_pkg;

    // Config port field selectors
    localparam logic [1:0] CFG_BASE = 2'd0;
    localparam logic [1:0] CFG_MASK = 2'd1;
    localparam logic [1:0] CFG_CTRL = 2'd2;

    // Bus-cycle FSM states
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] ACK    = 3'd3;
    localparam logic [2:0] TOUT   = 3'd4;
    localparam logic [2:0] BERR   = 3'd5;

    // Ctrl word layout: {wp, ws[WS_W-1:0], enable}
    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_WS_LSB = 1;

    function automatic int ctrl_wp_bit(input int ws_w);
        return ws_w + 1;
    endfunction

    // Power-up table: four fixed regions, remaining entries cleared
    localparam int RST_N = 4;

    function automatic logic [31:0] rst_base(input int i);
        case (i)
            0:       return 32'h0000_0000;
            1:       return 32'h0800_0000;
            2:       return 32'h0040_0000;
            3:       return 32'hF000_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] rst_mask(input int i);
        case (i)
            0:       return 32'hFFFF_8000;
            1:       return 32'hFFFC_0000;
            2:       return 32'hFFFF_0000;
            3:       return 32'hFC00_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic int rst_ws(input int i);
        case (i)
            1:       return 2;
            2:       return 1;
            3:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic rst_en(input int i);
        return (i < RST_N);
    endfunction

endpackage

// File: rtl/m68k_region_decoder_if.sv
// rtl/m68k_region_decoder_if.sv - 68k bus and config port bundle for the region decoder
interface m68k_region_decoder_if #(
    parameter int ADDR_W      = 32,
    parameter int NUM_REGIONS = 8,
    parameter int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
);
    logic [ADDR_W-1:0]      Address;
    logic                   AS_L;
    logic                   RW;
    logic                   Cfg_We_H;
    logic [IDX_W-1:0]       Cfg_Idx;
    logic [1:0]             Cfg_Field;
    logic [ADDR_W-1:0]      Cfg_WData;
    logic [ADDR_W-1:0]      Cfg_RData;
    logic [NUM_REGIONS-1:0] Select_H;
    logic                   DTACK_L;
    logic                   BERR_L;
    logic                   Busy_H;

    modport master (
        output Address, AS_L, RW, Cfg_We_H, Cfg_Idx, Cfg_Field, Cfg_WData,
        input  Cfg_RData, Select_H, DTACK_L, BERR_L, Busy_H
    );

    modport slave (
        input  Address, AS_L, RW, Cfg_We_H, Cfg_Idx, Cfg_Field, Cfg_WData,
        output Cfg_RData, Select_H, DTACK_L, BERR_L, Busy_H
    );
endinterface

// File: rtl/m68k_region_decoder_region_match.sv
// rtl/m68k_region_decoder_region_match.sv - single base/mask comparator for one decode entry
module region_match #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] address,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] mask,
    input  logic              enable,
    output logic              hit
);
    // Only address bits covered by the mask take part in the compare
    assign hit = enable && ((address & mask) == (base & mask));
endmodule

// File: rtl/m68k_region_decoder.sv
// rtl/m68k_region_decoder.sv - programmable 68k region decoder (optional REGION_WRITE_PROTECT_EN)
module m68k_region_decoder
    import m68k_decode_pkg::*;
#(
    parameter int NUM_REGIONS = 8,
    parameter int ADDR_W      = 32,
    parameter int WS_W        = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                 Clk,
    input  logic                 Reset_H,
    m68k_region_decoder_if.slave bus
);
    localparam int IDX_W   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int CTRL_W  = WS_W + 2;
    localparam int WP_BIT  = ctrl_wp_bit(WS_W);
    localparam int TCNT_W  = $clog2(TIMEOUT + 1);

`ifdef REGION_WRITE_PROTECT_EN
    localparam logic [CTRL_W-1:0] CTRL_KEEP = '1;
`else
    // Without write protection the WP bit is never stored, so it always reads 0
    localparam logic [CTRL_W-1:0] CTRL_KEEP = {1'b0, {(CTRL_W-1){1'b1}}};
`endif

    logic [ADDR_W-1:0] base_q [NUM_REGIONS];
    logic [ADDR_W-1:0] mask_q [NUM_REGIONS];
    logic [CTRL_W-1:0] ctrl_q [NUM_REGIONS];

    logic [NUM_REGIONS-1:0] hit;
    logic [NUM_REGIONS-1:0] hit_onehot;
    logic                   any_hit;
    logic [CTRL_W-1:0]      hit_ctrl;
    logic [WS_W-1:0]        hit_ws;
    logic                   wp_block;

    logic [2:0]             state;
    logic [NUM_REGIONS-1:0] sel_q;
    logic [WS_W-1:0]        wcnt;
    logic [TCNT_W-1:0]      tcnt;
    logic                   dtack_l;
    logic                   berr_l;

    // Region table: config writes land on the clock edge regardless of bus state
    always_ff @(posedge Clk) begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (Reset_H) begin
                base_q[i] <= ADDR_W'(rst_base(i));
                mask_q[i] <= ADDR_W'(rst_mask(i));
                ctrl_q[i] <= {1'b0, WS_W'(rst_ws(i)), rst_en(i)};
            end else if (bus.Cfg_We_H && (bus.Cfg_Idx == IDX_W'(i))) begin
                case (bus.Cfg_Field)
                    CFG_BASE: base_q[i] <= bus.Cfg_WData;
                    CFG_MASK: mask_q[i] <= bus.Cfg_WData;
                    CFG_CTRL: ctrl_q[i] <= bus.Cfg_WData[CTRL_W-1:0] & CTRL_KEEP;
                    default:  ;
                endcase
            end
        end
    end

    // Combinational readback; unknown field or out-of-range index reads 0
    always_comb begin
        bus.Cfg_RData = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (bus.Cfg_Idx == IDX_W'(i)) begin
                case (bus.Cfg_Field)
                    CFG_BASE: bus.Cfg_RData = base_q[i];
                    CFG_MASK: bus.Cfg_RData = mask_q[i];
                    CFG_CTRL: bus.Cfg_RData = ADDR_W'(ctrl_q[i]);
                    default:  bus.Cfg_RData = '0;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
        region_match #(.ADDR_W(ADDR_W)) u_match (
            .address (bus.Address),
            .base    (base_q[g]),
            .mask    (mask_q[g]),
            .enable  (ctrl_q[g][CTRL_EN_BIT]),
            .hit     (hit[g])
        );
    end

    // Priority encoder: scanning downward leaves the lowest-index hit as winner
    always_comb begin
        any_hit    = 1'b0;
        hit_onehot = '0;
        hit_ctrl   = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit    = 1'b1;
                hit_onehot = NUM_REGIONS'(1) << i;
                hit_ctrl   = ctrl_q[i];
            end
        end
    end

    assign hit_ws   = hit_ctrl[CTRL_WS_LSB +: WS_W];
    // WP bit can only be set when the feature is built in, so this is inert otherwise
    assign wp_block = !bus.RW && hit_ctrl[WP_BIT];

    // Bus-cycle FSM: decode, wait states, acknowledge, timeout and bus error
    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            state   <= IDLE;
            sel_q   <= '0;
            wcnt    <= '0;
            tcnt    <= '0;
            dtack_l <= 1'b1;
            berr_l  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.AS_L) state <= DECODE;
                end
                DECODE: begin
                    tcnt <= '0;
                    if (bus.AS_L) begin
                        state <= IDLE;
                    end else if (!any_hit) begin
                        state <= TOUT;
                    end else if (wp_block) begin
                        state  <= BERR;
                        berr_l <= 1'b0;
                    end else begin
                        sel_q <= hit_onehot;
                        wcnt  <= hit_ws;
                        state <= (hit_ws == '0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (bus.AS_L) begin
                        state <= IDLE;
                        sel_q <= '0;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt - WS_W'(1);
                        if (wcnt == WS_W'(1)) state <= ACK;
                    end
                end
                ACK: begin
                    if (bus.AS_L) begin
                        state   <= IDLE;
                        sel_q   <= '0;
                        dtack_l <= 1'b1;
                    end else begin
                        dtack_l <= 1'b0;
                    end
                end
                TOUT: begin
                    if (bus.AS_L) begin
                        state <= IDLE;
                        tcnt  <= '0;
                    end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                        state  <= BERR;
                        berr_l <= 1'b0;
                        tcnt   <= '0;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                BERR: begin
                    if (bus.AS_L) begin
                        state  <= IDLE;
                        berr_l <= 1'b1;
                    end else begin
                        berr_l <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    sel_q   <= '0;
                    dtack_l <= 1'b1;
                    berr_l  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.Select_H = sel_q;
    assign bus.DTACK_L  = dtack_l;
    assign bus.BERR_L   = berr_l;
    assign bus.Busy_H   = (state != IDLE);

endmodule
